mdu_issue_ctrl: RTL and testbench
=================================

Name: mdu_issue_ctrl

Overview:
- Execute-stage initiator for the shared multiply/divide unit. It accepts one RV64M operation from the pipeline, pre-resolves the architectural corner cases locally, and drives the MDU's one-hot op lines and operands.
- It then tracks the MDU's ready-based completion, captures the result, cancels the MDU's spurious restart, and presents a held result to writeback over a valid/ready handshake.
- Also owns W-variant extension and a hang watchdog.

Parameters:
- TIMEOUT, 96, maximum cycles in WAIT before aborting with error.
- CNT_W, 7, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  pipeline kill; cancels any operation
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_op  in  3  RV funct3: 0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu
- in_word  in  1  W-variant (mulw/divw/divuw/remw/remuw)
- in_src1  in  64  rs1 value
- in_src2  in  64  rs2 value
- in_rd  in  5  destination tag, returned unchanged
- out_valid  out  1  result valid, held until out_ready
- out_ready  in  1  writeback accepts
- out_result  out  64  final architectural result
- out_rd  out  5  tag of result
- out_err  out  1  set with out_valid on illegal op or watchdog abort
- mdu_mul, mdu_mulh, mdu_mulhu, mdu_mulhsu, mdu_div, mdu_divu, mdu_rem, mdu_remu  out  1 each  one-hot MDU op lines
- mdu_src1  out  64  MDU operand 1
- mdu_src2  out  64  MDU operand 2
- mdu_flush  out  1  one-cycle MDU cancel pulse
- mdu_result  in  64  MDU result, valid only on the first cycle mdu_ready is high after being low
- mdu_ready  in  1  MDU idle

Behaviour:
- Reset (reset=0, async):
  - State IDLE.
  - All registered outputs 0: out_valid, out_result, out_rd, out_err, op lines, mdu_src1/2, mdu_flush, watchdog counter, seen_low flag.
  - in_ready = (state==IDLE) & ~flush, so it reads 1 in reset.
- States: IDLE, ISSUE, WAIT, CANCEL, DONE. Only one operation is in flight; in_ready is 0 outside IDLE.
- Accept (IDLE):
  - Latch op, word and rd.
  - Operands for the MDU:
    - in_word=0: used as-is.
    - mulw/divw/remw: sign-extended from bit 31.
    - divuw/remuw: zero-extended from bit 31.
  - Special cases are evaluated on the effective width (32 if in_word, else 64), and the next state is DONE with the result computed locally (out_valid the cycle after accept):
    - Divisor zero: div/divu give all-ones; rem/remu give the dividend.
    - Signed overflow (div/rem, dividend = most-negative, divisor = -1): div gives the dividend; rem gives 0.
    - in_word with op 1..3: illegal; result 0 and out_err=1.
    - W special-case results are sign-extended from bit 31.
  - Otherwise the next state is ISSUE.
- ISSUE:
  - Assert exactly one mdu op line plus mdu_src1/2 from registers.
  - When mdu_ready=1 the MDU samples this cycle: go to WAIT, clear seen_low and the counter.
- WAIT:
  - Op lines and operands held.
  - Set seen_low when mdu_ready=0; the counter increments each cycle.
  - When mdu_ready=1 & seen_low: capture mdu_result into out_result (W: sign-extend bit 31), go to CANCEL.
  - When the counter reaches TIMEOUT: out_result=0, out_err=1, go to CANCEL.
- CANCEL:
  - Op lines 0, mdu_flush=1 for exactly this cycle. This kills the restart caused by the held op lines.
  - Next state DONE, or IDLE if cancel was entered via flush.
- DONE:
  - out_valid=1; out_result, out_rd and out_err stable.
  - On out_ready: next state IDLE, out_valid drops next cycle.
- Normal latency: out_valid rises 2 cycles after the mdu_ready rising cycle.
- flush (priority over everything):
  - In ISSUE or WAIT: go to CANCEL with drop flag set, so mdu_flush pulses and no result is produced.
  - In CANCEL: go to IDLE.
  - In DONE: out_valid is cleared at the next edge and the state goes to IDLE.
  - In IDLE: in_ready=0 that cycle and no accept occurs.
- Simultaneous flush with capture: flush wins and the result is discarded.
- mdu_ready high during WAIT without a prior low never completes (stale-ready guard); only the watchdog ends it.

Test Plan:
- mul, src1=7, src2=0xFFFFFFFFFFFFFFFD, MDU model latency 33 → out_result=0xFFFFFFFFFFFFFFEB, out_err=0; exactly one mdu_flush pulse after capture.
- div by zero, src1=100, src2=0 → out_valid 1 cycle after accept with 0xFFFFFFFFFFFFFFFF; rem, same operands → 100; no mdu op line ever asserted.
- divw, src1=0x0000000080000000, src2=0xFFFFFFFFFFFFFFFF → 0xFFFFFFFF80000000 bypassed; remw same operands → 0.
- mulw, src1=0x0000000040000000, src2=2 → MDU sees sign-extended operands; out_result=0xFFFFFFFF80000000.
- flush two cycles into WAIT → mdu_flush pulses once, out_valid stays 0, in_ready=1 two cycles later; next op completes correctly.
- out_ready held 0 for 5 cycles in DONE → out_valid/out_result stable, in_ready=0. Separately, mdu_ready stuck 0 → out_err=1, out_result=0 after TIMEOUT cycles.

Source files
------------

// File: rtl/mdu_issue_ctrl_if.sv
// Signal bundle between the execute-stage MDU issue controller, the pipeline,
// writeback and the shared multiply/divide unit.
interface mdu_issue_ctrl_if;
  // Handshakes: a transfer happens on a rising clock edge where valid and ready
  // are both high; valid never waits on ready, and once raised, valid and its
  // payload hold until that transfer (flush is the only exception).
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic        in_word;
  logic [63:0] in_src1;
  logic [63:0] in_src2;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [4:0]  out_rd;
  logic        out_err;
  logic        mdu_mul;
  logic        mdu_mulh;
  logic        mdu_mulhu;
  logic        mdu_mulhsu;
  logic        mdu_div;
  logic        mdu_divu;
  logic        mdu_rem;
  logic        mdu_remu;
  logic [63:0] mdu_src1;
  logic [63:0] mdu_src2;
  logic        mdu_flush;
  logic [63:0] mdu_result;
  logic        mdu_ready;
  logic [2:0]  dbg_state;

  modport master (
    input  flush, in_valid, in_op, in_word, in_src1, in_src2, in_rd,
    input  out_ready, mdu_result, mdu_ready,
    output in_ready, out_valid, out_result, out_rd, out_err,
    output mdu_mul, mdu_mulh, mdu_mulhu, mdu_mulhsu,
    output mdu_div, mdu_divu, mdu_rem, mdu_remu,
    output mdu_src1, mdu_src2, mdu_flush, dbg_state
  );

  modport slave (
    output flush, in_valid, in_op, in_word, in_src1, in_src2, in_rd,
    output out_ready, mdu_result, mdu_ready,
    input  in_ready, out_valid, out_result, out_rd, out_err,
    input  mdu_mul, mdu_mulh, mdu_mulhu, mdu_mulhsu,
    input  mdu_div, mdu_divu, mdu_rem, mdu_remu,
    input  mdu_src1, mdu_src2, mdu_flush, dbg_state
  );
endinterface

// File: rtl/mdu_issue_ctrl.sv
// RV64M issue controller: resolves divide corner cases locally, drives the
// shared MDU, captures its ready-based completion and hands results to writeback.
module mdu_issue_ctrl #(
  parameter int TIMEOUT = 96,
  parameter int CNT_W   = 7
) (
  input logic          clock,
  input logic          reset,
  mdu_issue_ctrl_if.master bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_CANCEL = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  logic [2:0]       state;
  logic             word_q;
  logic             drop_q;
  logic             seen_low;
  logic [CNT_W-1:0] wd_cnt;
  logic [7:0]       op_lines;
  logic [63:0]      src1_q;
  logic [63:0]      src2_q;
  logic             mdu_flush_q;
  logic             out_valid_q;
  logic [63:0]      out_result_q;
  logic [4:0]       out_rd_q;
  logic             out_err_q;

  logic        in_ready_c;
  logic        accept;
  logic [63:0] a_eff;
  logic [63:0] b_eff;
  logic [63:0] dividend_res;
  logic        b_zero;
  logic        a_min;
  logic        b_m1;
  logic        illegal;
  logic        bypass;
  logic [63:0] byp_result;
  logic        byp_err;

  assign in_ready_c = (state == S_IDLE) & ~bus.flush;
  assign accept     = bus.in_valid & in_ready_c;

  // W ops with funct3[0] set (divuw/remuw) see zero-extended operands.
  always_comb begin
    a_eff = bus.in_src1;
    b_eff = bus.in_src2;
    if (bus.in_word) begin
      a_eff = bus.in_op[0] ? {32'b0, bus.in_src1[31:0]} : sext32(bus.in_src1[31:0]);
      b_eff = bus.in_op[0] ? {32'b0, bus.in_src2[31:0]} : sext32(bus.in_src2[31:0]);
    end
  end

  assign dividend_res = bus.in_word ? sext32(bus.in_src1[31:0]) : bus.in_src1;
  assign b_zero  = bus.in_word ? (bus.in_src2[31:0] == 32'b0) : (bus.in_src2 == 64'b0);
  assign a_min   = bus.in_word ? (bus.in_src1[31:0] == 32'h8000_0000)
                               : (bus.in_src1 == {1'b1, 63'b0});
  assign b_m1    = bus.in_word ? (&bus.in_src2[31:0]) : (&bus.in_src2);
  assign illegal = bus.in_word & ~bus.in_op[2] & (bus.in_op[1:0] != 2'b00);

  // Corner cases that the MDU never sees; their results go straight to DONE.
  always_comb begin
    bypass     = 1'b0;
    byp_result = 64'b0;
    byp_err    = 1'b0;
    if (illegal) begin
      bypass  = 1'b1;
      byp_err = 1'b1;
    end else if (bus.in_op[2]) begin
      if (b_zero) begin
        bypass     = 1'b1;
        byp_result = bus.in_op[1] ? dividend_res : '1;
      end else if (~bus.in_op[0] & a_min & b_m1) begin
        bypass     = 1'b1;
        byp_result = bus.in_op[1] ? 64'b0 : dividend_res;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      word_q       <= 1'b0;
      drop_q       <= 1'b0;
      seen_low     <= 1'b0;
      wd_cnt       <= '0;
      op_lines     <= 8'b0;
      src1_q       <= 64'b0;
      src2_q       <= 64'b0;
      mdu_flush_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= 64'b0;
      out_rd_q     <= 5'b0;
      out_err_q    <= 1'b0;
    end else begin
      mdu_flush_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            word_q   <= bus.in_word;
            out_rd_q <= bus.in_rd;
            drop_q   <= 1'b0;
            if (bypass) begin
              out_result_q <= byp_result;
              out_err_q    <= byp_err;
              out_valid_q  <= 1'b1;
              state        <= S_DONE;
            end else begin
              op_lines  <= 8'(1) << bus.in_op;
              src1_q    <= a_eff;
              src2_q    <= b_eff;
              out_err_q <= 1'b0;
              state     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (bus.flush) begin
            op_lines    <= 8'b0;
            mdu_flush_q <= 1'b1;
            drop_q      <= 1'b1;
            state       <= S_CANCEL;
          end else if (bus.mdu_ready) begin
            wd_cnt   <= '0;
            seen_low <= 1'b0;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.flush) begin
            op_lines    <= 8'b0;
            mdu_flush_q <= 1'b1;
            drop_q      <= 1'b1;
            state       <= S_CANCEL;
          end else if (bus.mdu_ready & seen_low) begin
            out_result_q <= word_q ? sext32(bus.mdu_result[31:0]) : bus.mdu_result;
            out_err_q    <= 1'b0;
            op_lines     <= 8'b0;
            mdu_flush_q  <= 1'b1;
            state        <= S_CANCEL;
          end else if (wd_cnt == TMO) begin
            out_result_q <= 64'b0;
            out_err_q    <= 1'b1;
            op_lines     <= 8'b0;
            mdu_flush_q  <= 1'b1;
            state        <= S_CANCEL;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
            if (!bus.mdu_ready) seen_low <= 1'b1;
          end
        end
        // The op lines were still high when the MDU went ready, so it has
        // already restarted; the flush pulse issued on entry kills that.
        S_CANCEL: begin
          if (bus.flush | drop_q) begin
            drop_q <= 1'b0;
            state  <= S_IDLE;
          end else begin
            out_valid_q <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.flush | bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_rd     = out_rd_q;
  assign bus.out_err    = out_err_q;
  assign bus.mdu_mul    = op_lines[0];
  assign bus.mdu_mulh   = op_lines[1];
  assign bus.mdu_mulhsu = op_lines[2];
  assign bus.mdu_mulhu  = op_lines[3];
  assign bus.mdu_div    = op_lines[4];
  assign bus.mdu_divu   = op_lines[5];
  assign bus.mdu_rem    = op_lines[6];
  assign bus.mdu_remu   = op_lines[7];
  assign bus.mdu_src1   = src1_q;
  assign bus.mdu_src2   = src2_q;
  assign bus.mdu_flush  = mdu_flush_q;
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Bench for mdu_issue_ctrl: directed RV64M ops against a small MDU model with a
// scoreboard queue checked by an independent writeback monitor.
module tb_mdu_issue_ctrl;
  localparam int TIMEOUT = 96;
  localparam int LAT     = 33;

  logic clock;
  logic reset;
  mdu_issue_ctrl_if bus ();

  mdu_issue_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [69:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // MDU model: idle-high ready, samples an op while ready, busy for LAT cycles
  bit hang;
  bit stale;
  int busy_cnt;
  logic [7:0] ops;
  assign ops = {bus.mdu_remu, bus.mdu_rem, bus.mdu_divu, bus.mdu_div,
                bus.mdu_mulhu, bus.mdu_mulhsu, bus.mdu_mulh, bus.mdu_mul};

  function automatic logic [63:0] mdu_calc(input logic [7:0] o, input logic [63:0] a, input logic [63:0] b);
    if (o[0]) return a * b;
    if (o[5]) return (b == 64'b0) ? '1 : a / b;
    return a ^ b;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.mdu_ready  <= 1'b1;
      bus.mdu_result <= 64'b0;
      busy_cnt       <= 0;
    end else if (bus.mdu_flush) begin
      bus.mdu_ready <= 1'b1;
      busy_cnt      <= 0;
    end else if (busy_cnt > 0) begin
      if (!hang) begin
        busy_cnt <= busy_cnt - 1;
        if (busy_cnt == 1) begin
          bus.mdu_ready  <= 1'b1;
          bus.mdu_result <= mdu_calc(ops, bus.mdu_src1, bus.mdu_src2);
        end
      end
    end else if (bus.mdu_ready && (|ops) && !stale) begin
      bus.mdu_ready  <= 1'b0;
      bus.mdu_result <= 64'hBAD0_BAD0_BAD0_BAD0;
      busy_cnt       <= LAT;
    end
  end

  // monitor: scoreboard pops plus event counters
  int flush_cnt, opline_cnt, wait_cyc;
  int ready_rise = -1, valid_rise = -1;
  logic rdy_prev = 1'b1, val_prev = 1'b0;

  always @(negedge clock) begin
    if (reset) begin
      if (|ops) begin
        opline_cnt++;
        chk("op_onehot", 64'($countones(ops)), 64'd1);
      end
      if (bus.mdu_flush) flush_cnt++;
      if (bus.dbg_state == 3'd2) wait_cyc++;
      if (bus.mdu_ready && !rdy_prev && (|ops)) ready_rise = cyc;
      if (bus.out_valid && !val_prev) valid_rise = cyc;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got %h rd %0d err %0b expected none",
                   bus.out_result, bus.out_rd, bus.out_err);
        end else begin
          logic [69:0] e;
          e = exp_q.pop_front();
          chk("out_result", bus.out_result, e[63:0]);
          chk("out_rd", 64'(bus.out_rd), 64'(e[68:64]));
          chk("out_err", 64'(bus.out_err), 64'(e[69]));
        end
      end
      rdy_prev = bus.mdu_ready;
      val_prev = bus.out_valid;
    end
  end

  // driver tasks
  task automatic push_exp(input logic err, input logic [4:0] rd, input logic [63:0] res);
    exp_q.push_back({err, rd, res});
  endtask

  task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] rd);
    int g;
    g = 0;
    @(negedge clock);
    while (!bus.in_ready && g < 2000) begin
      @(negedge clock);
      g++;
    end
    chk("issue_ready", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_word  = w;
    bus.in_src1  = a;
    bus.in_src2  = b;
    bus.in_rd    = rd;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    @(negedge clock);
    while (!bus.in_ready && g < 2000) begin
      @(negedge clock);
      g++;
    end
    chk("idle_reached", 64'(bus.in_ready), 64'd1);
    repeat (2) @(negedge clock);
  endtask

  initial begin
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 3'd0;
    bus.in_word   = 1'b0;
    bus.in_src1   = 64'b0;
    bus.in_src2   = 64'b0;
    bus.in_rd     = 5'd0;
    bus.out_ready = 1'b1;
    hang  = 1'b0;
    stale = 1'b0;
    reset = 1'b0;
    #12;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_result", bus.out_result, 64'd0);
    chk("rst_out_err", 64'(bus.out_err), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_mdu_flush", 64'(bus.mdu_flush), 64'd0);
    chk("rst_ops", 64'(ops), 64'd0);
    chk("rst_state", 64'(bus.dbg_state), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // mul through the MDU
    flush_cnt = 0;
    push_exp(1'b0, 5'd3, 64'hFFFF_FFFF_FFFF_FFEB);
    issue(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd3);
    wait_idle();
    chk("mul_latency", 64'(valid_rise - ready_rise), 64'd2);
    chk("mul_flush_pulses", 64'(flush_cnt), 64'd1);

    // divide-by-zero and overflow bypasses
    opline_cnt = 0;
    push_exp(1'b0, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(3'd4, 1'b0, 64'd100, 64'd0, 5'd5);
    chk("divz_valid_next", 64'(bus.out_valid), 64'd1);
    wait_idle();
    push_exp(1'b0, 5'd6, 64'd100);
    issue(3'd6, 1'b0, 64'd100, 64'd0, 5'd6);
    chk("remz_valid_next", 64'(bus.out_valid), 64'd1);
    wait_idle();
    push_exp(1'b0, 5'd7, 64'hFFFF_FFFF_8000_0000);
    issue(3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7);
    chk("divw_valid_next", 64'(bus.out_valid), 64'd1);
    wait_idle();
    push_exp(1'b0, 5'd8, 64'd0);
    issue(3'd6, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8);
    wait_idle();
    push_exp(1'b0, 5'd10, 64'h8000_0000_0000_0000);
    issue(3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10);
    wait_idle();
    push_exp(1'b1, 5'd11, 64'd0);
    issue(3'd1, 1'b1, 64'd5, 64'd6, 5'd11);
    wait_idle();
    chk("bypass_no_oplines", 64'(opline_cnt), 64'd0);

    // W variants through the MDU: operand extension and result sign extension
    push_exp(1'b0, 5'd12, 64'hFFFF_FFFF_8000_0000);
    issue(3'd0, 1'b1, 64'h1234_5678_4000_0000, 64'hABCD_0000_0000_0002, 5'd12);
    chk("mulw_src1", bus.mdu_src1, 64'h0000_0000_4000_0000);
    chk("mulw_src2", bus.mdu_src2, 64'd2);
    chk("mulw_mul_line", 64'(bus.mdu_mul), 64'd1);
    wait_idle();
    push_exp(1'b0, 5'd13, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(3'd0, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd3, 5'd13);
    chk("mulw_neg_src1", bus.mdu_src1, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_idle();
    push_exp(1'b0, 5'd14, 64'h0000_0000_7FFF_FFF8);
    issue(3'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'h5555_0000_0000_0002, 5'd14);
    chk("divuw_src1", bus.mdu_src1, 64'h0000_0000_FFFF_FFF0);
    chk("divuw_src2", bus.mdu_src2, 64'd2);
    wait_idle();

    // flush two cycles into WAIT
    flush_cnt = 0;
    issue(3'd0, 1'b0, 64'd5, 64'd6, 5'd9);
    begin
      int g;
      g = 0;
      while (bus.dbg_state != 3'd2 && g < 100) begin
        @(negedge clock);
        g++;
      end
      chk("reached_wait", 64'(bus.dbg_state), 64'd2);
    end
    repeat (2) @(negedge clock);
    bus.flush = 1'b1;
    @(negedge clock);
    bus.flush = 1'b0;
    chk("flush_cancel_in_ready", 64'(bus.in_ready), 64'd0);
    chk("flush_cancel_pulse", 64'(bus.mdu_flush), 64'd1);
    @(negedge clock);
    chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    repeat (3) @(negedge clock);
    chk("flush_pulses", 64'(flush_cnt), 64'd1);
    push_exp(1'b0, 5'd15, 64'd143);
    issue(3'd0, 1'b0, 64'd11, 64'd13, 5'd15);
    wait_idle();

    // writeback stall in DONE
    bus.out_ready = 1'b0;
    push_exp(1'b0, 5'd16, 64'd6);
    issue(3'd0, 1'b0, 64'd2, 64'd3, 5'd16);
    begin
      int g;
      g = 0;
      while (!bus.out_valid && g < 200) begin
        @(negedge clock);
        g++;
      end
      chk("stall_valid_seen", 64'(bus.out_valid), 64'd1);
    end
    for (int i = 0; i < 5; i++) begin
      chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
      chk("stall_out_result", bus.out_result, 64'd6);
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
      @(negedge clock);
    end
    bus.out_ready = 1'b1;
    wait_idle();

    // MDU accepts then never completes: watchdog abort
    hang = 1'b1;
    wait_cyc = 0;
    push_exp(1'b1, 5'd17, 64'd0);
    issue(3'd0, 1'b0, 64'd4, 64'd4, 5'd17);
    wait_idle();
    chk("watchdog_wait_cycles", 64'(wait_cyc), 64'(TIMEOUT + 1));
    hang = 1'b0;

    // ready never drops: stale-ready guard holds until the watchdog
    stale = 1'b1;
    push_exp(1'b1, 5'd18, 64'd0);
    issue(3'd0, 1'b0, 64'd4, 64'd4, 5'd18);
    wait_idle();
    stale = 1'b0;

    push_exp(1'b0, 5'd19, 64'd42);
    issue(3'd0, 1'b0, 64'd6, 64'd7, 5'd19);
    wait_idle();

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
